// File: rtl/vpe_vadd_writeback.sv
// vpe_vadd_writeback: accumulate/ReLU/writeback of vector-adder results into a 32-entry RF with drain port and bulk clear
module vpe_vadd_writeback #(
  parameter int LANES = 8,
  parameter int LANE_W = 8,
  parameter int RF_DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] i_data,
  input  logic                    i_data_v,
  input  logic                    i_en_relu,
  input  logic [IDX_W-1:0]        i_rf_idx,
  input  logic [1:0]              i_rf_mux,
  input  logic                    i_rd_en,
  input  logic [IDX_W-1:0]        i_rd_idx,
  input  logic                    i_clr,
  output logic [LANES*LANE_W-1:0] o_rd_data,
  output logic                    o_rd_v,
  output logic [LANES*LANE_W-1:0] o_fwd_data,
  output logic                    o_fwd_v,
  output logic                    o_busy,
  output logic                    o_err
);
  localparam int DW = LANES * LANE_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_d;
  logic [IDX_W-1:0] clr_cnt;
  logic [DW-1:0] rf [RF_DEPTH];
  logic a_v, a_relu;
  logic [DW-1:0] a_data;
  logic [IDX_W-1:0] a_idx;
  logic [1:0] a_mux;
  logic [DW-1:0] base, res, rd_next;
  logic [LANE_W-1:0] lane_sum;
  logic busy, clr_last, wr_en, fwd_en, accept;
  assign busy = state == CLEAR;
  assign clr_last = clr_cnt == IDX_W'(RF_DEPTH - 1);
  assign wr_en = a_v && a_mux != 2'b10;
  assign fwd_en = a_v && a_mux[1];
  assign accept = i_data_v && !busy;
  assign o_busy = busy;
  // Clear sequence entered from IDLE only, so a second i_clr cannot restart it
  always_comb begin
    state_d = busy ? (clr_last ? IDLE : CLEAR) : (i_clr ? CLEAR : IDLE);
  end
  // Per-lane wrapping add on the accumulate base, then ReLU on the final value
  always_comb begin
    base = a_mux == 2'b01 ? rf[a_idx] : '0;
    res = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = a_data[i*LANE_W +: LANE_W] + base[i*LANE_W +: LANE_W];
      res[i*LANE_W +: LANE_W] = (a_relu && lane_sum[LANE_W-1]) ? '0 : lane_sum;
    end
  end
  // Write-first read: the entry's value after this edge, clear taking priority over the write
  assign rd_next = (busy && clr_cnt == i_rd_idx) ? '0 :
                   (wr_en && a_idx == i_rd_idx) ? res : rf[i_rd_idx];
  // FSM state and clear index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_d;
      clr_cnt <= busy ? clr_cnt + 1'b1 : '0;
    end
  end
  // Stage A capture; beats arriving during a clear are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v <= 1'b0;
      a_relu <= 1'b0;
      a_data <= '0;
      a_idx <= '0;
      a_mux <= '0;
    end else begin
      a_v <= accept;
      if (accept) begin
        a_relu <= i_en_relu;
        a_data <= i_data;
        a_idx <= i_rf_idx;
        a_mux <= i_rf_mux;
      end
    end
  end
  // Register file; the clear assignment is last so it wins on a same-entry collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < RF_DEPTH; j++) rf[j] <= '0;
    end else begin
      if (wr_en) rf[a_idx] <= res;
      if (busy) rf[clr_cnt] <= '0;
    end
  end
  // Registered drain, forward and sticky error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_v <= 1'b0;
      o_rd_data <= '0;
      o_fwd_v <= 1'b0;
      o_fwd_data <= '0;
      o_err <= 1'b0;
    end else begin
      o_rd_v <= i_rd_en;
      if (i_rd_en) o_rd_data <= rd_next;
      o_fwd_v <= fwd_en;
      if (fwd_en) o_fwd_data <= res;
      o_err <= o_err | (i_data_v && busy);
    end
  end
endmodule
